// File: rtl/arm_hazard_pkg.sv
// Shared types and helpers for the ARM pipeline hazard/forwarding unit.
package arm_hazard_pkg;

    localparam int unsigned DEST_W_MAX = 8;
    localparam int unsigned FWD_NONE   = 0;

    // Destination tag carried alongside each instruction past ID
    typedef struct packed {
        logic                  valid;
        logic                  wb_en;
        logic                  mem_r_en;
        logic [DEST_W_MAX-1:0] dest;
    } tag_t;

    function automatic int unsigned fwd_sel_w(input int unsigned num_stages);
        return (num_stages < 2) ? 1 : $clog2(num_stages);
    endfunction

endpackage

// File: rtl/tag_pipe.sv
// Shift register of destination tags for the stages after ID; entry 0 is EX.
module tag_pipe
    import arm_hazard_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bubble,
    input  tag_t                  in_tag,
    output tag_t [NUM_STAGES-1:0] tags
);

    tag_t [NUM_STAGES-1:0] tags_q;

    // Downstream stages never stall, so every entry shifts every cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            tags_q <= '0;
        end else begin
            tags_q[0] <= bubble ? tag_t'('0) : in_tag;
            for (int unsigned k = 1; k < NUM_STAGES; k++) begin
                tags_q[k] <= tags_q[k-1];
            end
        end
    end

    assign tags = tags_q;

endmodule

// File: rtl/hazard_fwd_unit.sv
// RAW hazard detection, forwarding-select generation and stall counting
// for the instruction in ID against all older in-flight instructions.
module hazard_fwd_unit
    import arm_hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 4,
    parameter int unsigned NUM_STAGES = 3,
    parameter bit          FWD_EN     = 1'b1,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          id_valid,
    input  logic [REG_ADDR_W-1:0]         id_src1,
    input  logic                          id_src1_en,
    input  logic [REG_ADDR_W-1:0]         id_src2,
    input  logic                          id_two_src,
    input  logic [REG_ADDR_W-1:0]         id_dest,
    input  logic                          id_wb_en,
    input  logic                          id_mem_r_en,
    input  logic                          flush,
    output logic                          freeze,
    output logic [$clog2(NUM_STAGES)-1:0] ex_fwd_sel_a,
    output logic [$clog2(NUM_STAGES)-1:0] ex_fwd_sel_b,
    output logic [CNT_W-1:0]              stall_cnt
);

    localparam int unsigned SEL_W = fwd_sel_w(NUM_STAGES);
    localparam int unsigned CMP_N = NUM_STAGES - 1;

    tag_t [NUM_STAGES-1:0] tags;
    tag_t                  id_tag_c;
    logic                  advance_c;
    logic                  hazard_c;
    logic [CMP_N-1:0]      hit_a_c;
    logic [CMP_N-1:0]      hit_b_c;
    logic [SEL_W-1:0]      sel_a_c;
    logic [SEL_W-1:0]      sel_b_c;
    logic                  unused_tags;

    assign id_tag_c = '{valid:    1'b1,
                        wb_en:    id_wb_en,
                        mem_r_en: id_mem_r_en,
                        dest:     DEST_W_MAX'(id_dest)};

    assign advance_c = id_valid && !freeze && !flush;

    tag_pipe #(
        .NUM_STAGES (NUM_STAGES)
    ) u_tag_pipe (
        .clk    (clk),
        .rst    (rst),
        .bubble (!advance_c),
        .in_tag (id_tag_c),
        .tags   (tags)
    );

    // WB entry and most load flags are carried but never compared
    assign unused_tags = ^tags;

    // Per-entry match of each enabled source; WB entry excluded
    always_comb begin
        hit_a_c = '0;
        hit_b_c = '0;
        for (int unsigned k = 0; k < CMP_N; k++) begin
            hit_a_c[k] = id_src1_en && tags[k].valid && tags[k].wb_en &&
                         (tags[k].dest == DEST_W_MAX'(id_src1));
            hit_b_c[k] = id_two_src && tags[k].valid && tags[k].wb_en &&
                         (tags[k].dest == DEST_W_MAX'(id_src2));
        end
    end

    always_comb begin
        hazard_c = 1'b0;
        sel_a_c  = SEL_W'(FWD_NONE);
        sel_b_c  = SEL_W'(FWD_NONE);
        if (FWD_EN) begin
            hazard_c = (hit_a_c[0] || hit_b_c[0]) && tags[0].mem_r_en;
            // Walk oldest to youngest so the youngest producer wins
            for (int k = int'(CMP_N) - 1; k >= 0; k--) begin
                if (hit_a_c[k]) begin
                    sel_a_c = SEL_W'(k + 1);
                end
                if (hit_b_c[k]) begin
                    sel_b_c = SEL_W'(k + 1);
                end
            end
        end else begin
            hazard_c = |{hit_a_c, hit_b_c};
        end
    end

    assign freeze = rst && id_valid && hazard_c && !flush;

    // Selects travel with the instruction into EX; bubbles carry no forwarding
    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_fwd_sel_a <= '0;
            ex_fwd_sel_b <= '0;
            stall_cnt    <= '0;
        end else begin
            ex_fwd_sel_a <= advance_c ? sel_a_c : SEL_W'(FWD_NONE);
            ex_fwd_sel_b <= advance_c ? sel_b_c : SEL_W'(FWD_NONE);
            if (freeze && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit: three configurations share stimulus, each checked
// against an issue-history model (select = age of youngest producer).
module tb_hazard_fwd_unit;

    localparam int unsigned RW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, id_valid, id_src1_en, id_two_src, id_wb_en, id_mem_r_en, flush;
    logic [RW-1:0] id_src1, id_src2, id_dest;
    logic          frz0, frz1, frz2;
    logic [1:0]    sa0, sb0, sa1, sb1, sa2, sb2;
    logic [31:0]   cnt0, cnt1;
    logic [1:0]    cnt2;

    hazard_fwd_unit #(.REG_ADDR_W(RW), .NUM_STAGES(3), .FWD_EN(1'b1), .CNT_W(32)) u_fwd (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src1_en(id_src1_en),
        .id_src2(id_src2), .id_two_src(id_two_src), .id_dest(id_dest), .id_wb_en(id_wb_en),
        .id_mem_r_en(id_mem_r_en), .flush(flush), .freeze(frz0),
        .ex_fwd_sel_a(sa0), .ex_fwd_sel_b(sb0), .stall_cnt(cnt0));

    hazard_fwd_unit #(.REG_ADDR_W(RW), .NUM_STAGES(3), .FWD_EN(1'b0), .CNT_W(32)) u_stall (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src1_en(id_src1_en),
        .id_src2(id_src2), .id_two_src(id_two_src), .id_dest(id_dest), .id_wb_en(id_wb_en),
        .id_mem_r_en(id_mem_r_en), .flush(flush), .freeze(frz1),
        .ex_fwd_sel_a(sa1), .ex_fwd_sel_b(sb1), .stall_cnt(cnt1));

    hazard_fwd_unit #(.REG_ADDR_W(RW), .NUM_STAGES(4), .FWD_EN(1'b0), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src1_en(id_src1_en),
        .id_src2(id_src2), .id_two_src(id_two_src), .id_dest(id_dest), .id_wb_en(id_wb_en),
        .id_mem_r_en(id_mem_r_en), .flush(flush), .freeze(frz2),
        .ex_fwd_sel_a(sa2), .ex_fwd_sel_b(sb2), .stall_cnt(cnt2));

    // Model: per configuration, a log of what entered EX in each cycle
    typedef struct {
        bit v;
        bit wb;
        bit ld;
        int dest;
    } rec_t;

    int              m_ns[3]  = '{3, 3, 4};
    bit              m_fwd[3] = '{1'b1, 1'b0, 1'b0};
    longint unsigned m_max[3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd3};

    rec_t            issued[3][1024];
    int              cyc      = 0;
    int              last_rst = -1;
    bit              e_frz[3];
    int              p_sa[3], p_sb[3];
    int              e_sa[3], e_sb[3];
    longint unsigned e_cnt[3];
    bit              o_frz[3];

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected freeze and would-be selects from the issue log and current ID inputs
    task automatic predict();
        bit   haz, m1, m2;
        int   sa, sb, c;
        rec_t r;
        for (int i = 0; i < 3; i++) begin
            haz = 1'b0;
            sa  = 0;
            sb  = 0;
            for (int age = m_ns[i] - 1; age >= 1; age--) begin
                c = cyc - age;
                if (c > last_rst) begin
                    r  = issued[i][c % 1024];
                    m1 = r.v && r.wb && id_src1_en && (r.dest == int'(id_src1));
                    m2 = r.v && r.wb && id_two_src && (r.dest == int'(id_src2));
                    if (m1) sa = age;
                    if (m2) sb = age;
                    if ((m1 || m2) && (!m_fwd[i] || (age == 1 && r.ld))) haz = 1'b1;
                end
            end
            e_frz[i] = rst && id_valid && haz && !flush;
            p_sa[i]  = m_fwd[i] ? sa : 0;
            p_sb[i]  = m_fwd[i] ? sb : 0;
        end
    endtask

    task automatic commit();
        bit iss;
        for (int i = 0; i < 3; i++) begin
            if (!rst) begin
                e_cnt[i] = 0;
                e_sa[i]  = 0;
                e_sb[i]  = 0;
                issued[i][cyc % 1024].v = 1'b0;
            end else begin
                iss = id_valid && !e_frz[i] && !flush;
                issued[i][cyc % 1024] = '{v: iss, wb: id_wb_en, ld: id_mem_r_en, dest: int'(id_dest)};
                e_sa[i] = iss ? p_sa[i] : 0;
                e_sb[i] = iss ? p_sb[i] : 0;
                if (e_frz[i] && e_cnt[i] < m_max[i]) e_cnt[i]++;
            end
        end
        if (!rst) last_rst = cyc;
        cyc++;
    endtask

    task automatic step(input bit r, input bit v, input int s1, input bit s1e, input int s2,
                        input bit two, input int d, input bit wb, input bit ld, input bit fl);
        rst = r; id_valid = v; id_src1 = RW'(s1); id_src1_en = s1e; id_src2 = RW'(s2);
        id_two_src = two; id_dest = RW'(d); id_wb_en = wb; id_mem_r_en = ld; flush = fl;
        #1;
        predict();
        o_frz[0] = frz0; o_frz[1] = frz1; o_frz[2] = frz2;
        check("freeze_fwd",   32'(frz0), 32'(e_frz[0]));
        check("freeze_stall", 32'(frz1), 32'(e_frz[1]));
        check("freeze_sat",   32'(frz2), 32'(e_frz[2]));
        @(posedge clk);
        #1;
        commit();
        check("sel_a_fwd",   32'(sa0),  32'(e_sa[0]));
        check("sel_b_fwd",   32'(sb0),  32'(e_sb[0]));
        check("cnt_fwd",     cnt0,      32'(e_cnt[0]));
        check("sel_a_stall", 32'(sa1),  32'(e_sa[1]));
        check("sel_b_stall", 32'(sb1),  32'(e_sb[1]));
        check("cnt_stall",   cnt1,      32'(e_cnt[1]));
        check("sel_a_sat",   32'(sa2),  32'(e_sa[2]));
        check("sel_b_sat",   32'(sb2),  32'(e_sb[2]));
        check("cnt_sat",     32'(cnt2), 32'(e_cnt[2]));
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic nop();
        step(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    // Hold the instruction in ID until the chosen DUT stops freezing it
    task automatic issue(input int inst, input int s1, input bit s1e, input int s2, input bit two,
                         input int d, input bit wb, input bit ld, output int n);
        n = 0;
        do begin
            step(1'b1, 1'b1, s1, s1e, s2, two, d, wb, ld, 1'b0);
            n++;
        end while (o_frz[inst] && n < 8);
        if (o_frz[inst]) begin
            compared++;
            mismatched++;
            $error("FAIL issue_timeout inst=%0d observed freeze=1 expected freeze=0", inst);
        end
    endtask

    initial begin
        int n;

        // Reset held while a matching instruction sits in ID
        step(1'b0, 1'b1, 1, 1'b1, 1, 1'b1, 1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1, 1'b1, 1, 1'b1, 1, 1'b1, 1'b1, 1'b0);
        check("rst_freeze", 32'(frz0), 32'd0);
        check("rst_sel_a", 32'(sa0), 32'd0);
        check("rst_cnt", cnt0, 32'd0);

        // ADD R1 then SUB R2,R1,R3 back to back
        issue(0, 2, 1'b1, 0, 1'b0, 1, 1'b1, 1'b0, n);
        issue(0, 1, 1'b1, 3, 1'b1, 2, 1'b1, 1'b0, n);
        check("b2b_no_freeze", 32'(n), 32'd1);
        check("b2b_sel_a", 32'(sa0), 32'd1);
        check("b2b_sel_b", 32'(sb0), 32'd0);

        // ADD R1, independent MOV R7, SUB reading R1
        do_reset();
        issue(0, 2, 1'b1, 0, 1'b0, 1, 1'b1, 1'b0, n);
        issue(0, 0, 1'b0, 0, 1'b0, 7, 1'b1, 1'b0, n);
        issue(0, 1, 1'b1, 3, 1'b1, 2, 1'b1, 1'b0, n);
        check("gap_sel_a", 32'(sa0), 32'd2);

        // Load-use: LDR R4 then ADD R5,R4,R4
        do_reset();
        issue(0, 0, 1'b0, 0, 1'b0, 4, 1'b1, 1'b1, n);
        issue(0, 4, 1'b1, 4, 1'b1, 5, 1'b1, 1'b0, n);
        check("lu_cycles", 32'(n), 32'd2);
        check("lu_sel_a", 32'(sa0), 32'd2);
        check("lu_sel_b", 32'(sb0), 32'd2);
        check("lu_cnt", cnt0, 32'd1);

        // Stall-only: ADD R1 then ORR R6,R1
        do_reset();
        issue(1, 2, 1'b1, 0, 1'b0, 1, 1'b1, 1'b0, n);
        issue(1, 1, 1'b1, 0, 1'b0, 6, 1'b1, 1'b0, n);
        check("so_cycles", 32'(n), 32'd3);
        check("so_sel_a", 32'(sa1), 32'd0);
        check("so_cnt", cnt1, 32'd2);

        // Flush beats a load-use freeze
        do_reset();
        issue(0, 0, 1'b0, 0, 1'b0, 4, 1'b1, 1'b1, n);
        step(1'b1, 1'b1, 4, 1'b1, 4, 1'b1, 5, 1'b1, 1'b0, 1'b1);
        check("flush_freeze", 32'(o_frz[0]), 32'd0);
        check("flush_sel_a", 32'(sa0), 32'd0);
        check("flush_cnt", cnt0, 32'd0);
        step(1'b1, 1'b1, 4, 1'b1, 4, 1'b1, 5, 1'b1, 1'b0, 1'b0);
        check("post_flush_freeze", 32'(o_frz[0]), 32'd0);
        check("post_flush_sel_a", 32'(sa0), 32'd2);

        // Reset in the middle of a stall
        do_reset();
        issue(1, 2, 1'b1, 0, 1'b0, 1, 1'b1, 1'b0, n);
        step(1'b1, 1'b1, 1, 1'b1, 0, 1'b0, 6, 1'b1, 1'b0, 1'b0);
        check("mid_stall_freeze", 32'(o_frz[1]), 32'd1);
        step(1'b0, 1'b1, 1, 1'b1, 0, 1'b0, 6, 1'b1, 1'b0, 1'b0);
        check("rst_stall_freeze", 32'(o_frz[1]), 32'd0);
        step(1'b1, 1'b1, 1, 1'b1, 0, 1'b0, 6, 1'b1, 1'b0, 1'b0);
        check("after_rst_freeze", 32'(o_frz[1]), 32'd0);
        check("after_rst_cnt", cnt1, 32'd0);

        // Counter saturation: two dependencies of three freezes each on a 2-bit counter
        do_reset();
        for (int j = 0; j < 2; j++) begin
            issue(2, 2, 1'b1, 0, 1'b0, 1, 1'b1, 1'b0, n);
            issue(2, 1, 1'b1, 0, 1'b0, 6, 1'b1, 1'b0, n);
        end
        check("sat_cnt", 32'(cnt2), 32'd3);
        nop();
        check("sat_hold", 32'(cnt2), 32'd3);

        // Random traffic over a small register window to provoke dependencies
        for (int j = 0; j < 400; j++) begin
            step($urandom_range(0, 39) != 0, $urandom_range(0, 3) != 0,
                 int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
